// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state encoding, grant encoding and timeout default
// for the instruction/data memory arbiter and its bench.
package mem_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, FETCH_WAIT, DATA_WAIT, DONE} state_t;
    typedef enum logic {GNT_FETCH, GNT_DATA} grant_t;
    localparam int TIMEOUT_DEFAULT = 16;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, data port, memory port and status lines.
//   fetch: if_req, if_addr -> if_rdata, if_ready
//   data : d_req, d_we, d_addr, d_wdata -> d_rdata, d_ready
//   mem  : m_req, m_we, m_addr, m_wdata -> memory; m_rdata, m_ack <- memory
//   stat : stall, err
// slave is the arbiter's view; master is the CPU/memory side driving it.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        stall;
    logic        err;
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        output if_rdata, if_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata, stall, err
    );
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        input  if_rdata, if_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata, stall, err
    );
endinterface

// File: rtl/mem_arbiter_wait_timer.sv
// wait_timer: counts memory wait cycles and flags the last one allowed.
//   clk, reset (sync, active-low); clr zeroes the count; en advances it;
//   tc is high when the count equals TIMEOUT-1.
module wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tc = cnt_q == W'(TIMEOUT - 1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access.
//   clk, reset (sync, active-low), bus (mem_arbiter_if.slave).
//   Contended requests alternate; a wait beyond TIMEOUT cycles aborts the access
//   with zero read data, a normal ready pulse and a sticky err.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    state_t      state_q, state_d;
    grant_t      last_q, last_d;
    logic        m_req_q, m_req_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        if_ready_q, if_ready_d;
    logic        d_ready_q, d_ready_d;
    logic        err_q, err_d;
    logic        tc;
    logic        waiting;
    logic        take_data;
    logic [31:0] rdata;

    assign waiting   = state_q == FETCH_WAIT || state_q == DATA_WAIT;
    // Data wins when alone, or when contended and fetch was served last.
    assign take_data = bus.d_req & (~bus.if_req | last_q == GNT_FETCH);
    // A timed-out access returns zero instead of whatever is on m_rdata.
    assign rdata     = bus.m_ack ? bus.m_rdata : 32'h0;

    wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == IDLE),
        .en    (waiting & ~bus.m_ack),
        .tc    (tc)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_ready_d = 1'b0;
        d_ready_d  = 1'b0;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (take_data) begin
                    state_d   = DATA_WAIT;
                    last_d    = GNT_DATA;
                    m_req_d   = 1'b1;
                    m_we_d    = bus.d_we;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                end else if (bus.if_req) begin
                    state_d   = FETCH_WAIT;
                    last_d    = GNT_FETCH;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = bus.if_addr;
                    m_wdata_d = 32'h0;
                end
            end
            FETCH_WAIT, DATA_WAIT: begin
                if (bus.m_ack || tc) begin
                    state_d = DONE;
                    m_req_d = 1'b0;
                    err_d   = err_q | ~bus.m_ack;
                    if (state_q == FETCH_WAIT) begin
                        if_rdata_d = rdata;
                        if_ready_d = 1'b1;
                    end else begin
                        d_rdata_d = rdata;
                        d_ready_d = 1'b1;
                    end
                end
            end
            // Requests are not sampled here, so a req still held during the
            // ready pulse cannot start a second access.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_q     <= GNT_DATA;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= 32'h0;
            m_wdata_q  <= 32'h0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_ready_q <= if_ready_d;
            d_ready_q  <= d_ready_d;
            err_q      <= err_d;
        end
    end

    assign bus.m_req    = m_req_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.if_ready = if_ready_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.d_ready  = d_ready_q;
    assign bus.err      = err_q;
    assign bus.stall    = (bus.if_req & ~if_ready_q) | (bus.d_req & ~d_ready_q);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of fetch, store, contention, timeout, reset abort
// and held-request behaviour of mem_arbiter.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.if_req  = 1'b0;
        bus.if_addr = 32'h0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        bus.m_rdata = 32'h0;
        bus.m_ack   = 1'b0;

        // reset state
        tick();
        tick();
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_m_req", 32'(bus.m_req), 32'd0);
        chk("rst_m_addr", bus.m_addr, 32'h0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        chk("rst_err", 32'(bus.err), 32'd0);
        reset = 1'b1;
        tick();

        // single fetch, zero wait
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0040_0000;
        tick();
        chk("fetch_m_req", 32'(bus.m_req), 32'd1);
        chk("fetch_m_addr", bus.m_addr, 32'h0040_0000);
        chk("fetch_m_we", 32'(bus.m_we), 32'd0);
        chk("fetch_stall", 32'(bus.stall), 32'd1);
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'h8C82_0004;
        tick();
        chk("fetch_ready", 32'(bus.if_ready), 32'd1);
        chk("fetch_rdata", bus.if_rdata, 32'h8C82_0004);
        chk("fetch_m_req_drop", 32'(bus.m_req), 32'd0);
        chk("fetch_stall_rdy", 32'(bus.stall), 32'd0);
        bus.m_ack  = 1'b0;
        bus.if_req = 1'b0;
        tick();
        chk("fetch_ready_1cyc", 32'(bus.if_ready), 32'd0);
        chk("fetch_idle", 32'(dut.state_q), 32'(IDLE));

        // store with 3 wait cycles
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h1001_0000;
        bus.d_wdata = 32'hCAFE_F00D;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("st_m_req", 32'(bus.m_req), 32'd1);
            chk("st_m_we", 32'(bus.m_we), 32'd1);
            chk("st_m_wdata", bus.m_wdata, 32'hCAFE_F00D);
            chk("st_m_addr", bus.m_addr, 32'h1001_0000);
            chk("st_no_ready", 32'(bus.d_ready), 32'd0);
            if (i < 3) tick();
        end
        bus.m_ack = 1'b1;
        tick();
        chk("st_ready", 32'(bus.d_ready), 32'd1);
        chk("st_m_req_drop", 32'(bus.m_req), 32'd0);
        bus.m_ack = 1'b0;
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        tick();
        chk("st_ready_1cyc", 32'(bus.d_ready), 32'd0);

        // contention: last grant was data, so fetch goes first
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0040_0100;
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h1001_0040;
        bus.m_rdata = 32'h0000_1234;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            while (!bus.m_req && n < 5) begin
                tick();
                n++;
            end
            chk("cont_grant_seen", 32'(bus.m_req), 32'd1);
            chk("cont_addr", bus.m_addr, (t % 2 == 0) ? 32'h0040_0100 : 32'h1001_0040);
            bus.m_ack = 1'b1;
            tick();
            chk("cont_ready", 32'({bus.if_ready, bus.d_ready}), (t % 2 == 0) ? 32'd2 : 32'd1);
            bus.m_ack = 1'b0;
            tick();
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        tick();
        chk("cont_d_rdata", bus.d_rdata, 32'h0000_1234);

        // timeout on a load with no ack
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h1001_0080;
        tick();
        n = 0;
        while (bus.m_req && n < 40) begin
            n++;
            tick();
        end
        chk("to_cycles", 32'(n), 32'(TIMEOUT_DEFAULT));
        chk("to_ready", 32'(bus.d_ready), 32'd1);
        chk("to_rdata", bus.d_rdata, 32'h0);
        chk("to_err", 32'(bus.err), 32'd1);
        bus.d_req = 1'b0;
        tick();
        tick();
        tick();
        chk("to_err_sticky", 32'(bus.err), 32'd1);
        bus.m_ack = 1'b1;
        tick();
        chk("ack_idle_state", 32'(dut.state_q), 32'(IDLE));
        chk("ack_idle_ready", 32'({bus.if_ready, bus.d_ready}), 32'd0);
        bus.m_ack = 1'b0;
        reset = 1'b0;
        tick();
        chk("rst_clears_err", 32'(bus.err), 32'd0);
        reset = 1'b1;
        tick();

        // reset during FETCH_WAIT, then a late ack
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0040_0200;
        tick();
        tick();
        chk("ra_wait", 32'(dut.state_q), 32'(FETCH_WAIT));
        reset = 1'b0;
        bus.if_req = 1'b0;
        tick();
        chk("ra_m_req", 32'(bus.m_req), 32'd0);
        chk("ra_state", 32'(dut.state_q), 32'(IDLE));
        reset = 1'b1;
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'hDEAD_BEEF;
        tick();
        chk("ra_no_ready", 32'(bus.if_ready), 32'd0);
        chk("ra_state2", 32'(dut.state_q), 32'(IDLE));
        chk("ra_rdata", bus.if_rdata, 32'h0);
        bus.m_ack = 1'b0;
        tick();
        chk("ra_no_ready2", 32'(bus.if_ready), 32'd0);

        // held fetch request through DONE
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0040_0300;
        bus.m_rdata = 32'h1111_2222;
        tick();
        chk("hold_m_req", 32'(bus.m_req), 32'd1);
        chk("hold_stall", 32'(bus.stall), 32'd1);
        bus.m_ack = 1'b1;
        tick();
        chk("hold_ready", 32'(bus.if_ready), 32'd1);
        chk("hold_stall_rdy", 32'(bus.stall), 32'd0);
        chk("hold_no_req_done", 32'(bus.m_req), 32'd0);
        bus.m_ack = 1'b0;
        tick();
        chk("hold_no_dup", 32'(bus.m_req), 32'd0);
        chk("hold_idle", 32'(dut.state_q), 32'(IDLE));
        chk("hold_stall_idle", 32'(bus.stall), 32'd1);
        tick();
        chk("hold_regrant", 32'(bus.m_req), 32'd1);
        bus.m_rdata = 32'h3333_4444;
        bus.m_ack   = 1'b1;
        tick();
        chk("hold_ready2", 32'(bus.if_ready), 32'd1);
        chk("hold_rdata2", bus.if_rdata, 32'h3333_4444);
        bus.m_ack  = 1'b0;
        bus.if_req = 1'b0;
        tick();
        tick();
        chk("hold_end_m_req", 32'(bus.m_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: memory wait cycles allowed before abort.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-low.
REQ-004 if_req  input  1  fetch request; held until if_ready.
REQ-005 if_addr  input  32  fetch address (PC value).
REQ-006 if_rdata  output  32  fetched instruction word.
REQ-007 if_ready  output  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-008 d_req  input  1  data request; held until d_ready.
REQ-009 d_we  input  1  1 = store, 0 = load.
REQ-010 d_addr  input  32  data address (ALU result).
REQ-011 d_wdata  input  32  store data (rd2).
REQ-012 d_rdata  output  32  load data.
REQ-013 d_ready  output  1  one-cycle pulse: data access complete.
REQ-014 m_req  output  1  memory request, registered.
REQ-015 m_we  output  1  memory write enable, registered.
REQ-016 m_addr  output  32  memory address, registered.
REQ-017 m_wdata  output  32  memory write data, registered.
REQ-018 m_rdata  input  32  memory read data, valid when m_ack=1.
REQ-019 m_ack  input  1  memory completion strobe.
REQ-020 stall  output  1  high while any asserted request has not yet received its ready pulse; freezes the PC.
REQ-021 err  output  1  sticky timeout flag.

Function
REQ-022 FSM states: IDLE, FETCH_WAIT, DATA_WAIT, DONE.
REQ-023 IDLE: only d_req -> DATA_WAIT; only if_req -> FETCH_WAIT; both -> grant the requester not granted last (last_grant flag, reset value = data, so the first contended grant goes to fetch); neither -> stay.
REQ-024 On the grant edge: m_req=1 and m_addr/m_we/m_wdata are loaded from the granted port; fetch grants force m_we=0 and m_wdata=0.
REQ-025 m_addr, m_we and m_wdata SHALL stay stable while m_req=1.
REQ-026 In a WAIT state with m_ack=1: capture m_rdata into the granted port's rdata register, drop m_req, go to DONE.
REQ-027 DONE lasts exactly one cycle; the granted port's ready=1; next state IDLE.
REQ-028 Minimum latency: req sampled in IDLE at cycle n, m_req=1 at n+1; m_ack at n+1 gives ready at n+2.
REQ-029 In DONE, the request from the port just served is ignored, so a held req does not cause a duplicate access.
REQ-030 Wait counter clears on grant and increments each WAIT cycle without m_ack.
REQ-031 Timeout: when the counter reaches TIMEOUT-1 without m_ack, drop m_req, set err, load 32'h0 into the granted rdata register, and go to DONE with the normal ready pulse.
REQ-032 m_ack in IDLE or DONE is ignored.
REQ-033 if_rdata and d_rdata hold their last value until overwritten by their own port.
REQ-034 stall = (if_req & ~if_ready) | (d_req & ~d_ready), combinational.

Reset
REQ-035 With reset=0 at a clock edge: state=IDLE, m_req=m_we=0, m_addr=m_wdata=0, if_rdata=d_rdata=0, ready pulses=0, err=0, counter=0, last_grant=data.
REQ-036 Reset mid-transaction aborts it with no ready pulse; a late m_ack after reset is ignored per REQ-032.

Structure
REQ-037 State encodings and the TIMEOUT default are defined in a shared include beside registers.v and used by RTL and bench.
REQ-038 The wait counter with terminal-count output is one sub-module, wait_timer.

Verification
REQ-039 Single fetch: if_req=1, if_addr=0x00400000, m_ack at first m_req cycle with m_rdata=0x8C820004 -> if_ready at n+2, if_rdata=0x8C820004, m_we=0.
REQ-040 Store: d_req=1, d_we=1, d_addr=0x10010000, d_wdata=0xCAFEF00D, 3 wait cycles -> m_we=1 and m_wdata stable for 4 cycles, d_ready one cycle after m_ack.
REQ-041 Contention: if_req and d_req held together for 4 back-to-back transactions -> grant order fetch, data, fetch, data.
REQ-042 Timeout: d_req load, m_ack never asserted -> m_req drops after 16 cycles, d_ready pulses, d_rdata=0, err=1 until reset.
REQ-043 Reset during FETCH_WAIT, then m_ack -> no if_ready, m_req=0, state IDLE.
REQ-044 Held req: if_req kept high through DONE -> exactly one memory access per ready pulse; stall is 1 from request to ready and 0 on the ready cycle.
